// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   state_t   : one-hot serialiser states (IDLE..DONE)
//   PAR_ODD   : parity code selecting an odd parity bit
//   PAR_EVEN  : parity code selecting an even parity bit
//   parity_of : maps a parity code and the XOR of the data to the parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [5:0] {
        IDLE   = 6'b000001,
        START  = 6'b000010,
        DATA   = 6'b000100,
        PARITY = 6'b001000,
        STOP   = 6'b010000,
        DONE   = 6'b100000
    } state_t;

    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    // Odd parity makes the total count of ones odd, so it is the inverse of
    // the plain XOR of the data; even parity is the XOR itself.
    function automatic logic parity_of(input logic [1:0] mode, input logic data_xor);
        return (mode == PAR_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_tick_gen
// Oversampling timebase. A free-running counter runs 0..DIV-1 with
// DIV = floor(clk_freq / (BAUD * oversampling_rate)); tick is high for exactly
// one clock on the edge after the counter reaches DIV-1.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous, active-high reset
//   tick  out  one-clock pulse every DIV clocks
// -----------------------------------------------------------------------------
module uart_tick_gen #(
    parameter int BAUD              = 9600,
    parameter int clk_freq          = 50_000_000,
    parameter int oversampling_rate = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV   = clk_freq / (BAUD * oversampling_rate);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 1) begin : g_bad_div
        $error("uart_tick_gen: clk_freq too low for BAUD * oversampling_rate");
    end

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == CNT_W'(DIV - 1)) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_top.sv
// -----------------------------------------------------------------------------
// uart_tx_top
// UART transmitter: oversampling tick generator plus a one-hot serialiser.
// Frame = start(0), data_wd bits LSB first, optional parity bit, stop(1).
// Configuration macro:
//   UART_TX_TWO_STOP_EN  defined   -> stop bit lasts 2 bit periods
//                        undefined -> 1 stop bit (default)
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   tx_start  in   request to send din; only looked at in IDLE
//   din       in   parallel data, captured on the accepting edge
//   tick      out  oversampling tick, shared timebase for a receiver
//   tx        out  serial line, idles high
//   tx_done   out  one-clock pulse once the stop bit has completed
//   tx_busy   out  high while a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx_top
    import uart_pkg::*;
#(
    parameter int         BAUD              = 9600,
    parameter int         clk_freq          = 50_000_000,
    parameter int         clk_period        = 20,
    parameter int         oversampling_rate = 16,
    parameter int         data_wd           = 8,
    parameter logic [1:0] parity            = 2'd1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_start,
    input  logic [data_wd-1:0] din,
    output logic               tick,
    output logic               tx,
    output logic               tx_done,
    output logic               tx_busy
);

    // clk_period is documentation of the intended clock; nothing depends on it.
    if (clk_period < 1) begin : g_bad_period
        $error("uart_tx_top: clk_period must be positive");
    end

`ifdef UART_TX_TWO_STOP_EN
    localparam int STOP_TICKS = 2 * oversampling_rate;
`else
    localparam int STOP_TICKS = oversampling_rate;
`endif

    localparam int  TC_W       = $clog2(2 * oversampling_rate);
    localparam int  BI_W       = (data_wd > 1) ? $clog2(data_wd) : 1;
    localparam bit  HAS_PARITY = (parity == PAR_ODD) || (parity == PAR_EVEN);

    state_t             c_state, state_next;
    logic [TC_W-1:0]    tick_count, tick_count_next;
    logic [BI_W-1:0]    bit_index, bit_index_next;
    logic [data_wd-1:0] data_reg, data_next;
    logic               parity_res, parity_next;
    logic               tx_next, tx_done_next, tx_busy_next;
    logic               bit_end, stop_end;

    uart_tick_gen #(
        .BAUD              (BAUD),
        .clk_freq          (clk_freq),
        .oversampling_rate (oversampling_rate)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // The edge consuming the last tick of a bit period advances the FSM.
    assign bit_end  = tick && (tick_count == TC_W'(oversampling_rate - 1));
    assign stop_end = tick && (tick_count == TC_W'(STOP_TICKS - 1));

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next      = c_state;
        tick_count_next = tick_count;
        bit_index_next  = bit_index;
        data_next       = data_reg;
        parity_next     = parity_res;

        unique case (c_state)
            IDLE: begin
                if (tx_start) begin
                    data_next       = din;
                    parity_next     = parity_of(parity, ^din);
                    tick_count_next = '0;
                    bit_index_next  = '0;
                    state_next      = START;
                end
            end
            START, DATA, PARITY: begin
                if (bit_end) begin
                    tick_count_next = '0;
                    if (c_state == START) begin
                        bit_index_next = '0;
                        state_next     = DATA;
                    end else if (c_state == PARITY) begin
                        state_next = STOP;
                    end else if (bit_index == BI_W'(data_wd - 1)) begin
                        bit_index_next = '0;
                        state_next     = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        bit_index_next = bit_index + BI_W'(1);
                    end
                end else if (tick) begin
                    tick_count_next = tick_count + TC_W'(1);
                end
            end
            STOP: begin
                if (stop_end) begin
                    tick_count_next = '0;
                    state_next      = DONE;
                end else if (tick) begin
                    tick_count_next = tick_count + TC_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so tx never
        // glitches while the data mux select changes.
        tx_next      = 1'b1;
        tx_done_next = 1'b0;
        tx_busy_next = 1'b1;
        unique case (state_next)
            IDLE:    tx_busy_next = 1'b0;
            START:   tx_next      = 1'b0;
            DATA:    tx_next      = data_next[bit_index_next];
            PARITY:  tx_next      = parity_next;
            STOP:    tx_next      = 1'b1;
            DONE: begin
                tx_done_next = 1'b1;
                tx_busy_next = 1'b0;
            end
            default: tx_busy_next = 1'b0;
        endcase
    end

    // NOTE: the data register is reset along with the control state; it is a
    // single word, and a known value keeps tx deterministic after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_state    <= IDLE;
            tick_count <= '0;
            bit_index  <= '0;
            data_reg   <= '0;
            parity_res <= 1'b0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
            tx_busy    <= 1'b0;
        end else begin
            c_state    <= state_next;
            tick_count <= tick_count_next;
            bit_index  <= bit_index_next;
            data_reg   <= data_next;
            parity_res <= parity_next;
            tx         <= tx_next;
            tx_done    <= tx_done_next;
            tx_busy    <= tx_busy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_top.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_top
// Directed bench for uart_tx_top. The clock frequency is chosen so the tick
// divider is 4, keeping each frame short. Each bit is sampled after the 12th
// tick of its 16-tick period, counted from the first tick the serialiser sees.
// -----------------------------------------------------------------------------
module tb_uart_tx_top;

    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int CLK_FREQ = 9600 * OS * DIV;
    localparam int LIMIT    = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tick, tx, tx_done, tx_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    uart_tx_top #(
        .BAUD              (9600),
        .clk_freq          (CLK_FREQ),
        .clk_period        (20),
        .oversampling_rate (OS),
        .data_wd           (8),
        .parity            (2'd1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .din      (din),
        .tick     (tick),
        .tx       (tx),
        .tx_done  (tx_done),
        .tx_busy  (tx_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drop the request and scramble din: the frame in flight must not notice.
    task automatic release_start();
        tx_start = 1'b0;
        din      = ~din;
    endtask

    // Follows one frame from its start bit to the tx_done pulse. If hold > 0,
    // tx_start is released hold clocks after the call.
    task automatic check_frame(input logic [7:0] b, input int hold, input string tag);
        logic [10:0] exp_bits;
        int g, ticks, bitn, clk_n;
        exp_bits = {1'b1, ~^b, b, 1'b0};
        g     = 0;
        clk_n = 0;
        while (tx !== 1'b0 && g < LIMIT) begin
            @(negedge clk);
            g++;
            clk_n++;
            if (hold > 0 && clk_n == hold) release_start();
        end
        check({tag, " start_seen"}, tx, 0);
        if (tx !== 1'b0) return;
        check({tag, " busy"}, tx_busy, 1);
        ticks = 0;
        bitn  = 0;
        while (bitn < 11 && g < LIMIT) begin
            if (tick === 1'b1) begin
                ticks++;
                if (ticks == 12) check($sformatf("%s bit%0d", tag, bitn), tx, exp_bits[bitn]);
                if (ticks == OS) begin
                    ticks = 0;
                    bitn++;
                end
            end
            if (bitn < 11) begin
                @(negedge clk);
                g++;
                clk_n++;
                if (hold > 0 && clk_n == hold) release_start();
            end
        end
        check({tag, " all_bits"}, bitn, 11);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (tx_done !== 1'b1 && g < 4);
        check({tag, " done_pulse"}, tx_done, 1);
        @(negedge clk);
        check({tag, " done_one_clk"}, tx_done, 0);
    endtask

    logic [7:0] bytes [5];
    int g, ticks, bad;

    initial begin
        // Test 1: reset values
        @(negedge clk);
        check("t1 tx", tx, 1);
        check("t1 tx_done", tx_done, 0);
        check("t1 tx_busy", tx_busy, 0);
        check("t1 tick", tick, 0);
        check("t1 tick_count", dut.tick_count, 0);
        check("t1 bit_index", dut.bit_index, 0);
        check("t1 c_state", dut.c_state, 6'b000001);
        rst = 1'b0;

        // Tick generator: one clock wide, period DIV
        g = 0;
        while (tick !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("tick_seen", tick, 1);
        @(negedge clk);
        check("tick_width", tick, 0);
        g = 1;
        while (tick !== 1'b1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("tick_period", g, DIV);

        // Test 2: 0xD3, odd parity, tx_start held for 2 clocks
        @(negedge clk);
        din      = 8'hD3;
        tx_start = 1'b1;
        @(negedge clk);
        check("t2 c_state_start", dut.c_state, 6'b000010);
        check_frame(8'hD3, 1, "t2");

        // Test 3: 5 back-to-back random bytes with tx_start held throughout
        for (int k = 0; k < 5; k++) bytes[k] = 8'($urandom_range(0, 255));
        @(negedge clk);
        din      = bytes[0];
        tx_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_frame(bytes[k], 0, $sformatf("t3 f%0d", k));
            if (k < 4) din = bytes[k + 1];
            else tx_start = 1'b0;
        end

        // Test 4: tx_start high well into the frame; no restart afterwards
        @(negedge clk);
        din      = 8'h5A;
        tx_start = 1'b1;
        check_frame(8'h5A, 300, "t4");
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || dut.c_state !== 6'b000001) bad++;
        end
        check("t4 no_restart", bad, 0);

        // Test 5: reset after 4 data bits of 0xD3
        din      = 8'hD3;
        tx_start = 1'b1;
        g = 0;
        while (tx !== 1'b0 && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        tx_start = 1'b0;
        check("t5 start_seen", tx, 0);
        ticks = 0;
        while (ticks < 5 * OS && g < LIMIT) begin
            if (tick === 1'b1) ticks++;
            if (ticks < 5 * OS) begin
                @(negedge clk);
                g++;
            end
        end
        @(negedge clk);
        check("t5 bit_index_pre", dut.bit_index, 4);
        check("t5 busy_pre", tx_busy, 1);
        rst = 1'b1;
        #1;
        check("t5 c_state", dut.c_state, 6'b000001);
        check("t5 tx", tx, 1);
        check("t5 tx_busy", tx_busy, 0);
        check("t5 tx_done", tx_done, 0);
        check("t5 tick_count", dut.tick_count, 0);
        check("t5 bit_index", dut.bit_index, 0);
        check("t5 tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5 idle_after", dut.c_state, 6'b000001);

        // Test 6: corner bytes
        din      = 8'hFF;
        tx_start = 1'b1;
        check_frame(8'hFF, 2, "t6 ff");
        @(negedge clk);
        din      = 8'h00;
        tx_start = 1'b1;
        check_frame(8'h00, 2, "t6 00");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
